axppa_pipelined_multi_operand_adder: RTL and testbench
======================================================

AXPPA_PIPELINED_MULTI_OPERAND_ADDER -- requirements
Module: axppa_pipelined_multi_operand_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, legal range 4..64.
REQ-002 Parameter APPROX_BITS, default 4: number of approximated LSBs (K), legal range 0..WIDTH.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1: sole clock, rising edge.
REQ-005 Port reset  input  1: asynchronous active-low reset.
REQ-006 Port in_valid  input  1: operand set offered.
REQ-007 Port in_ready  output  1: block accepts the operand set this cycle.
REQ-008 Port mode  input  1: 0 = a+b+c, 1 = a+b-c; sampled with the operands.
REQ-009 Ports a_input, b_input, c_input  input  WIDTH each: operands, unsigned.
REQ-010 Port out_valid  output  1: sum_output holds a result.
REQ-011 Port out_ready  input  1: consumer accepts the result.
REQ-012 Port sum_output  output  WIDTH+2: result, two's complement in mode 1.
REQ-013 Port txn_count  output  32: number of completed output handshakes.

Function
REQ-014 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-015 Three-stage pipeline: S1 = register operands + carry-save compression, S2 = Brent-Kung prefix generate/propagate, S3 = sum and output register.
REQ-016 Global advance = !out_valid | out_ready; in_ready SHALL equal advance; when advance is 0 all stages hold.
REQ-017 Latency SHALL be 3 cycles from input handshake to out_valid with no stall; throughput 1 result/cycle.
REQ-018 Per-stage valid bits SHALL propagate with data; bubbles SHALL not produce outputs; order is preserved.
REQ-019 W2 = WIDTH+2; operands are zero-extended to W2; in mode 1, c' = bitwise NOT of zext(c) over W2 bits and cin = 1, else c' = zext(c), cin = 0.
REQ-020 CSA: s = a ^ b ^ c'; cy = (maj(a,b,c') << 1) with cy[0] = cin, truncated to W2.
REQ-021 Exact region (bits K..W2-1): exact prefix addition of s and cy with carry-in defined by REQ-022.
REQ-022 Approximate region (bits 0..K-1): result bit i = s[i] | cy[i]; carry into bit K = s[K-1] & cy[K-1]; K = 0 means fully exact.
REQ-023 Result SHALL be taken modulo 2^W2; with K = 0 it equals (a+b+c) in mode 0 and (a+b-c) mod 2^W2 in mode 1.
REQ-024 While out_valid = 1 and out_ready = 0, sum_output SHALL remain stable.
REQ-025 txn_count SHALL increment by 1 on each output handshake and wrap from 0xFFFFFFFF to 0.
REQ-026 Simultaneous input and output handshake in the same cycle SHALL lose no data.

Reset
REQ-027 On reset assertion all stage valid bits, out_valid and txn_count SHALL clear to 0 immediately; sum_output SHALL clear to 0.
REQ-028 in_ready SHALL read 1 during and after reset (pipeline empty).
REQ-029 Reset mid-operation discards all in-flight operand sets; no result for them SHALL appear.
REQ-030 Reset release is synchronised externally; the first input handshake may occur on the first rising edge after deassertion.

Configuration
REQ-031 Macro AXPPA_APPROX_EN: when defined, REQ-022 applies with K = APPROX_BITS.
REQ-032 When AXPPA_APPROX_EN is undefined, K is forced to 0 and all results are exact regardless of APPROX_BITS; latency and handshake are unchanged.

Verification (WIDTH=16, APPROX_BITS=4)
REQ-033 Macro defined, mode 0, a=0x0003 b=0x0005 c=0x0001 -> sum_output=0x00007 three cycles later; macro undefined -> 0x00009.
REQ-034 Macro undefined, mode 1, a=0x0010 b=0x0000 c=0x0020 -> sum_output=0x3FFF0 (-16 in 18 bits).
REQ-035 Macro undefined, mode 0, a=b=c=0xFFFF -> sum_output=0x2FFFD.
REQ-036 out_ready held low 6 cycles while 4 back-to-back sets are offered -> exactly 3 accepted, in_ready low from the 4th; output held stable; after release, results emerge in order with no loss or duplication.
REQ-037 Reset asserted with 2 sets in flight -> out_valid=0 and txn_count=0 immediately; no stale result after release.
REQ-038 Preload 0xFFFFFFFE handshakes (force) then complete 2 results -> txn_count reads 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/axppa_pipelined_multi_operand_adder.sv
// axppa_pipelined_multi_operand_adder
// Three-stage pipelined three-operand adder: a+b+c (mode 0) or a+b-c (mode 1).
//   S1: register carry-save compression of the zero-extended operands
//   S2: Brent-Kung prefix carries over the exact region
//   S3: final sum and output register
// Optional feature macro AXPPA_APPROX_EN: when defined, the low APPROX_BITS
// result bits use an OR approximation with a single AND-generated carry into
// the exact region; when undefined the adder is fully exact.
// All stages advance together when the output is empty or being consumed.
module axppa_pipelined_multi_operand_adder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a_input,
  input  logic [WIDTH-1:0]   b_input,
  input  logic [WIDTH-1:0]   c_input,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   sum_output,
  output logic [31:0]        txn_count
);

  localparam int unsigned W2 = WIDTH + 2;
`ifdef AXPPA_APPROX_EN
  localparam int unsigned K = APPROX_BITS;
`else
  localparam int unsigned K = 0;
`endif
  // Exact region bits K..W2-1; prefix slot 0 carries the carry-in, slot j>0
  // holds bit K+j-1. The carry out of the top bit is never needed.
  localparam int unsigned NE  = W2 - K;
  localparam int unsigned KM1 = (K > 0) ? K - 1 : 0;
  localparam int unsigned TOP = 2 ** ($clog2(NE) - 1);
  localparam logic [W2-1:0] AMASK = {W2{1'b1}} >> (W2 - K);

  logic          advance;

  logic [W2-1:0] s_c, cy_c;
  logic          v1;
  logic [W2-1:0] s1, cy1;

  logic [W2-1:0] x_c, car_c;
  logic          v2;
  logic [W2-1:0] x2, car2;

  logic [W2-1:0] sum_q;
  logic [31:0]   txn_q;

  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance;
  assign sum_output = sum_q;
  assign txn_count  = txn_q;

  // Carry-save compression of a, b and c' (c inverted with carry-in for subtract).
  always_comb begin
    logic [W2-1:0] az, bz, cz, maj;
    az   = {2'b00, a_input};
    bz   = {2'b00, b_input};
    cz   = mode ? ~{2'b00, c_input} : {2'b00, c_input};
    maj  = (az & bz) | (az & cz) | (bz & cz);
    s_c  = az ^ bz ^ cz;
    cy_c = (maj << 1) | {{(W2 - 1){1'b0}}, mode};
  end

  // Stage 1 register: valid bit and carry-save vectors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1  <= 1'b0;
      s1  <= '0;
      cy1 <= '0;
    end else if (advance) begin
      v1  <= in_valid;
      s1  <= s_c;
      cy1 <= cy_c;
    end
  end

  // Brent-Kung prefix over the exact region; approximate bits are s|cy.
  always_comb begin
    logic [NE-1:0] g, p;
    g    = '0;
    p    = '0;
    g[0] = (K > 0) ? (s1[KM1] & cy1[KM1]) : 1'b0;
    for (int unsigned j = 1; j < NE; j++) begin
      g[j] = s1[K + j - 1] & cy1[K + j - 1];
      p[j] = s1[K + j - 1] ^ cy1[K + j - 1];
    end
    // Up-sweep builds power-of-two spans; down-sweep fills the remaining slots.
    for (int unsigned d = 1; d < NE; d = d * 2) begin
      for (int unsigned i = 2 * d - 1; i < NE; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i - d]);
        p[i] = p[i] & p[i - d];
      end
    end
    for (int unsigned d = TOP / 2; d >= 1; d = d / 2) begin
      for (int unsigned i = 3 * d - 1; i < NE; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i - d]);
        p[i] = p[i] & p[i - d];
      end
    end
    // After the scan g[j] is the carry into result bit K+j.
    car_c = W2'(g) << K;
    x_c   = (AMASK & (s1 | cy1)) | (~AMASK & (s1 ^ cy1));
  end

  // Stage 2 register: half-sum / approximate bits and resolved carries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2   <= 1'b0;
      x2   <= '0;
      car2 <= '0;
    end else if (advance) begin
      v2   <= v1;
      x2   <= x_c;
      car2 <= car_c;
    end
  end

  // Stage 3 register: final sum, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      sum_q     <= '0;
    end else if (advance) begin
      out_valid <= v2;
      sum_q     <= x2 ^ car2;
    end
  end

  // Completed output handshake counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txn_q <= '0;
    end else if (out_valid && out_ready) begin
      txn_q <= txn_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_axppa_pipelined_multi_operand_adder.sv
// Scoreboard bench for axppa_pipelined_multi_operand_adder (WIDTH=16, APPROX_BITS=4).
// Expected values are hand-computed for both builds of AXPPA_APPROX_EN.
module tb_axppa_pipelined_multi_operand_adder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] a_input, b_input, c_input;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] sum_output;
  logic [31:0] txn_count;

  axppa_pipelined_multi_operand_adder #(
    .WIDTH       (16),
    .APPROX_BITS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .a_input    (a_input),
    .b_input    (b_input),
    .c_input    (c_input),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_output (sum_output),
    .txn_count  (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [15:0] a, b, c;
    logic [17:0] e;
  } vec_t;

`ifdef AXPPA_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [17:0] expq[$];
  logic [31:0] exp_txn = '0;
  vec_t        vecs[7];
  vec_t        svecs[4];

  function automatic vec_t mk(logic m, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                              logic [17:0] ex, logic [17:0] ap);
    vec_t v;
    v.m = m; v.a = a; v.b = b; v.c = c;
    v.e = APPROX ? ap : ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    mode = v.m; a_input = v.a; b_input = v.b; c_input = v.c;
    in_valid = 1'b1;
  endtask

  // Offer one set at a negedge, wait (bounded) for acceptance, then log it.
  task automatic send(input vec_t v);
    int g;
    @(negedge clk);
    drive(v);
    #1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else expq.push_back(v.e);
    @(posedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expq.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", expq.size(), 0);
  endtask

  // Monitor: samples 2 units after each negedge, away from the rising edge.
  bit          held = 1'b0;
  logic [17:0] held_sum;
  always begin
    @(negedge clk);
    #2;
    if (reset !== 1'b1) begin
      held = 1'b0;
    end else begin
      check("txn_count", txn_count, exp_txn);
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum_output, held_sum);
      end
      if (out_valid) begin
        if (out_ready) begin
          if (expq.size() == 0) check("unexpected_output", sum_output, 18'h0);
          else check("sum_output", sum_output, expq.pop_front());
          exp_txn = exp_txn + 32'd1;
        end
        held     = !out_ready;
        held_sum = sum_output;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    vecs[0] = mk(1'b0, 16'h0003, 16'h0005, 16'h0001, 18'h00009, 18'h00007);
    vecs[1] = mk(1'b1, 16'h0010, 16'h0000, 16'h0020, 18'h3FFF0, 18'h3FFEF);
    vecs[2] = mk(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 18'h2FFFD, 18'h2FFFF);
    vecs[3] = mk(1'b0, 16'h1234, 16'h0100, 16'h0001, 18'h01335, 18'h01335);
    vecs[4] = mk(1'b1, 16'h0005, 16'h0003, 16'h0002, 18'h00006, 18'h0000B);
    vecs[5] = mk(1'b1, 16'h0000, 16'h0000, 16'h0000, 18'h00000, 18'h3FFFF);
    vecs[6] = mk(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 18'h10000, 18'h0FFFE);
    svecs[0] = mk(1'b0, 16'h0001, 16'h0002, 16'h0003, 18'h00006, 18'h00006);
    svecs[1] = mk(1'b0, 16'h0004, 16'h0004, 16'h0004, 18'h0000C, 18'h0000C);
    svecs[2] = mk(1'b0, 16'h0010, 16'h0020, 16'h0030, 18'h00060, 18'h00060);
    svecs[3] = mk(1'b0, 16'h0100, 16'h0000, 16'h0000, 18'h00100, 18'h00100);

    reset = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
    a_input = '0; b_input = '0; c_input = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_txn", txn_count, 0);
    check("rst_sum", sum_output, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Latency: handshake at E0, out_valid only after the third edge.
    send(vecs[0]);
    @(negedge clk); in_valid = 1'b0; #1;
    check("lat_e0", out_valid, 0);
    @(negedge clk); #1;
    check("lat_e1", out_valid, 0);
    @(negedge clk); #1;
    check("lat_e2", out_valid, 1);
    drain();

    // Back-to-back directed vectors.
    for (int i = 1; i < 7; i++) send(vecs[i]);
    @(negedge clk); in_valid = 1'b0;
    drain();

    // Stall: out_ready low for 6 cycles while 4 sets are offered.
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 6) out_ready = 1'b1;
      drive(svecs[(k < 3) ? k : 3]);
      #1;
      check("stall_in_ready", in_ready, (k < 3 || k == 6) ? 1 : 0);
      if (in_ready) expq.push_back(svecs[(k < 3) ? k : 3].e);
    end
    @(negedge clk); in_valid = 1'b0;
    drain();

    // Reset with two sets in flight (one presented, one in S2).
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[2]); #1;
    if (in_ready) expq.push_back(vecs[2].e);
    @(negedge clk);
    drive(vecs[6]); #1;
    if (in_ready) expq.push_back(vecs[6].e);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    check("pre_reset_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_txn", txn_count, 0);
    check("mid_rst_sum", sum_output, 0);
    check("mid_rst_in_ready", in_ready, 1);
    expq.delete();
    exp_txn = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("post_rst_no_output", out_valid, 0);

    // Counter wrap: preload near the top, then complete two results.
    @(negedge clk);
    #3;
    force dut.txn_q = 32'hFFFF_FFFE;
    #1;
    release dut.txn_q;
    exp_txn = 32'hFFFF_FFFE;
    check("preload_txn", txn_count, 32'hFFFF_FFFE);
    send(vecs[0]);
    send(vecs[3]);
    @(negedge clk); in_valid = 1'b0;
    drain();
    @(negedge clk); #1;
    check("wrap_txn", txn_count, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
